multi_drink_controller: RTL and testbench

MULTI_DRINK_CONTROLLER -- requirements
Module: multi_drink_controller

---
 rtl/coffee_pkg.sv | 13 +
 rtl/coffee_timer.sv | 19 +
 rtl/multi_drink_controller.sv | 117 +++++++++++
 tb/tb_multi_drink_controller.sv | 137 +++++++++++++
 4 files changed

// File: rtl/coffee_pkg.sv
// coffee_pkg: shared state codes, state width and cup-counter constants
package coffee_pkg;
    localparam int STATE_W = 3;
    localparam int CUPS_W = 8;
    localparam logic [CUPS_W-1:0] CUPS_MAX = 8'd255;
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        HEAT  = 3'd1,
        POUR  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;
endpackage

// File: rtl/coffee_timer.sv
// coffee_timer: TW-bit loadable down-counter with zero flag (clk, rst, load, dec, ld_val -> cnt, zero)
module coffee_timer #(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    input  logic [TW-1:0] ld_val,
    output logic [TW-1:0] cnt,
    output logic          zero
);
    assign zero = (cnt == '0);
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= ld_val;
        else if (dec && !zero) cnt <= cnt - TW'(1);
    end
endmodule

// File: rtl/multi_drink_controller.sv
// multi_drink_controller: drink brewer FSM (CLK, RST, SEL, A, V, B -> P, AQ, PP, M, STATE, DRINK, REM, CUPS)
module multi_drink_controller
    import coffee_pkg::*;
#(
    parameter int N_DRINKS  = 3,
    parameter int VOL_W     = 2,
    parameter int HEAT_CYC  = 16,
    parameter int POUR_UNIT = 8,
    parameter int DONE_CYC  = 8,
    parameter int BLINK_DIV = 2,
    parameter int TW        = 16,
    localparam int DW       = $clog2(N_DRINKS)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [N_DRINKS-1:0] SEL,
    input  logic                A,
    input  logic [VOL_W-1:0]    V,
    input  logic [VOL_W-1:0]    B,
    output logic                P,
    output logic                AQ,
    output logic                PP,
    output logic                M,
    output logic [STATE_W-1:0]  STATE,
    output logic [DW-1:0]       DRINK,
    output logic [TW-1:0]       REM,
    output logic [CUPS_W-1:0]   CUPS
);
    state_t st, nxt;
    logic a_q, rise, vl, onehot, load, dec, zero, latch, cups_inc;
    logic [VOL_W-1:0] vol;
    logic [DW-1:0] idx;
    logic [TW-1:0] ld_val, cnt;
    logic [BLINK_DIV:0] bc, bc_nxt;

    assign rise = A & ~a_q;
    assign vl = (V == B);
    assign onehot = ($countones(SEL) == 1);
    assign STATE = st;
    assign REM = (st == HEAT || st == POUR || st == DONE) ? cnt : '0;

    always_comb begin
        idx = '0;
        for (int i = 0; i < N_DRINKS; i++)
            if (SEL[i]) idx = DW'(i);
    end

    coffee_timer #(.TW(TW)) u_timer (
        .clk(CLK), .rst(RST), .load(load), .dec(dec),
        .ld_val(ld_val), .cnt(cnt), .zero(zero)
    );

    // Tamper (VL=0) outranks timer expiry in HEAT and POUR.
    always_comb begin
        nxt = st;
        load = 1'b0;
        dec = 1'b0;
        ld_val = '0;
        latch = 1'b0;
        cups_inc = 1'b0;
        case (st)
            IDLE: if (rise) begin
                if (onehot && vl && V != '0) begin
                    latch = 1'b1;
                    load = 1'b1;
                    ld_val = TW'(HEAT_CYC - 1);
                    nxt = HEAT;
                end else nxt = ERROR;
            end
            HEAT: if (!vl) nxt = ERROR;
                else if (zero) begin
                    load = 1'b1;
                    ld_val = TW'(vol) * TW'(POUR_UNIT) - TW'(1);
                    nxt = POUR;
                end else dec = 1'b1;
            POUR: if (!vl) nxt = ERROR;
                else if (zero) begin
                    load = 1'b1;
                    ld_val = TW'(DONE_CYC - 1);
                    cups_inc = 1'b1;
                    nxt = DONE;
                end else dec = 1'b1;
            DONE: if (zero) nxt = IDLE;
                else dec = 1'b1;
            ERROR: if (rise) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Blink phase restarts at 0 on every entry into ERROR.
    assign bc_nxt = (nxt == ERROR && st == ERROR) ? bc + 1'b1 : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            st <= IDLE;
            a_q <= 1'b0;
            vol <= '0;
            DRINK <= '0;
            CUPS <= '0;
            bc <= '0;
            {P, AQ, PP, M} <= 4'b0;
        end else begin
            st <= nxt;
            a_q <= A;
            bc <= bc_nxt;
            if (latch) begin
                vol <= V;
                DRINK <= idx;
            end
            if (cups_inc && CUPS != CUPS_MAX) CUPS <= CUPS + 1'b1;
            AQ <= (nxt == HEAT);
            P <= (nxt == POUR);
            PP <= (nxt == DONE);
            M <= bc_nxt[BLINK_DIV];
        end
    end
endmodule

// File: tb/tb_multi_drink_controller.sv
// tb_multi_drink_controller: directed + random stimulus against a phase/elapsed-time reference model
module tb_multi_drink_controller;
    localparam int HEAT_CYC = 16, POUR_UNIT = 8, DONE_CYC = 8, BLINK_DIV = 2;

    logic clk = 1'b0, rst = 1'b1, a = 1'b0;
    logic [2:0] sel = 3'b001;
    logic [1:0] v = 2'd0, b = 2'd0;
    logic p, aq, pp, m;
    logic [2:0] state;
    logic [1:0] drink;
    logic [15:0] rem;
    logic [7:0] cups;

    int total = 0, passed = 0, fails = 0;
    int m_st = 0, m_t = 0, m_len = 0, m_vol = 0, m_drink = 0, m_cups = 0;
    bit m_aprev = 1'b0;

    multi_drink_controller dut (
        .CLK(clk), .RST(rst), .SEL(sel), .A(a), .V(v), .B(b),
        .P(p), .AQ(aq), .PP(pp), .M(m), .STATE(state),
        .DRINK(drink), .REM(rem), .CUPS(cups)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model tracks phase and cycles elapsed in it; remaining = length - 1 - elapsed.
    task automatic model();
        bit rise, vl;
        rise = a && !m_aprev;
        vl = (v == b);
        if (rst) begin
            m_st = 0; m_t = 0; m_cups = 0; m_drink = 0; m_aprev = 1'b0;
            return;
        end
        m_aprev = a;
        case (m_st)
            0: if (rise) begin
                m_t = 0;
                if ($countones(sel) == 1 && vl && v != 0) begin
                    for (int i = 0; i < 3; i++) if (sel[i]) m_drink = i;
                    m_vol = v; m_st = 1; m_len = HEAT_CYC;
                end else m_st = 4;
            end
            1, 2: if (!vl) begin
                m_st = 4; m_t = 0;
            end else if (m_t == m_len - 1) begin
                m_t = 0;
                if (m_st == 1) begin
                    m_st = 2; m_len = m_vol * POUR_UNIT;
                end else begin
                    m_st = 3; m_len = DONE_CYC;
                    if (m_cups < 255) m_cups++;
                end
            end else m_t++;
            3: if (m_t == m_len - 1) m_st = 0; else m_t++;
            default: if (rise) m_st = 0; else m_t++;
        endcase
    endtask

    task automatic check();
        chk("STATE", state, m_st);
        chk("AQ", aq, m_st == 1);
        chk("P", p, m_st == 2);
        chk("PP", pp, m_st == 3);
        chk("M", m, m_st == 4 ? (m_t >> BLINK_DIV) & 1 : 0);
        chk("REM", rem, (m_st >= 1 && m_st <= 3) ? m_len - 1 - m_t : 0);
        chk("DRINK", drink, m_drink);
        chk("CUPS", cups, m_cups);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model();
            #1;
            check();
        end
    endtask

    task automatic press(input int after);
        a = 1'b1; step(1);
        a = 1'b0; step(after);
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        sel = 3'b001; v = 2'd2; b = 2'd2;
        step(2);
        press(45);
        sel = 3'b011;
        press(12);
        press(2);
        sel = 3'b001; v = 2'd1; b = 2'd3;
        press(3);
        press(2);
        v = 2'd0; b = 2'd0;
        press(3);
        press(2);
        v = 2'd3; b = 2'd3; sel = 3'b100;
        press(21);
        b = 2'd2;
        step(3);
        press(2);
        v = 2'd2; b = 2'd2; sel = 3'b010;
        press(5);
        rst = 1'b1; step(1);
        rst = 1'b0; step(3);
        a = 1'b1; step(50);
        a = 1'b0; step(2);
        v = 2'd1; b = 2'd1;
        repeat (257) press(35);
        chk("CUPS_SAT", cups, 255);
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) a = ~a;
            if ($urandom_range(0, 29) == 0)
                sel = ($urandom_range(0, 3) != 0) ? 3'(1 << $urandom_range(0, 2)) : 3'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                v = 2'($urandom);
                b = ($urandom_range(0, 3) == 0) ? 2'($urandom) : v;
            end
            step(1);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
